// File: rtl/power_sequencer.sv
// power_sequencer: ordered bring-up and reverse-order shutdown of N_RAILS
// PMIC regulator enables, with a latched all-off fault state on timeout,
// rail fault or loss of a rail that had already reported good.
//
// Control signalling (no valid/ready pairs in this block):
//   i_start is a level. High requests the rails on, low requests them off.
//   i_clearFault is a level and acts only in FAULT, and only on a cycle where
//   i_start is low. Every input is sampled on the rising edge of i_clk.
//   All outputs, including the o_dbgState state mirror, are registered.
module power_sequencer #(
   parameter int N_RAILS        = 4,
   parameter int TIMEOUT_CYCLES = 4000,
   parameter int DWELL_CYCLES   = 1000
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_clearFault,
   input  logic [N_RAILS-1:0] i_railGood,
   input  logic [N_RAILS-1:0] i_railFault,
   output logic [N_RAILS-1:0] o_railEnable,
   output logic               o_allGood,
   output logic               o_fault,
   output logic [2:0]         o_faultRail,
   output logic [1:0]         o_faultCode,
   output logic [2:0]         o_dbgState
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ENABLE   = 3'd1,
      ST_DWELL    = 3'd2,
      ST_RUNNING  = 3'd3,
      ST_SHUTDOWN = 3'd4,
      ST_FAULT    = 3'd5
   } state_t;

   localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
   localparam logic [2:0]  K_LAST     = 3'(N_RAILS - 1);

   localparam logic [1:0] CODE_NONE    = 2'b00;
   localparam logic [1:0] CODE_TIMEOUT = 2'b01;
   localparam logic [1:0] CODE_RAIL    = 2'b10;
   localparam logic [1:0] CODE_LOST    = 2'b11;

   // Sequencer state, current rail index and shared cycle counter.
   state_t             state_q, state_d;
   logic [2:0]         k_q, k_d;
   logic [15:0]        cnt_q, cnt_d;

   // Rails that have reported good since the last bring-up started.
   logic [N_RAILS-1:0] seen_q, seen_d;

   // Registered outputs.
   logic [N_RAILS-1:0] en_q, en_d;
   logic               all_good_q, all_good_d;
   logic               fault_q, fault_d;
   logic [2:0]         frail_q, frail_d;
   logic [1:0]         fcode_q, fcode_d;

   // Decoded helpers.
   logic [N_RAILS-1:0] k_onehot;
   logic [N_RAILS-1:0] fault_vec;
   logic [N_RAILS-1:0] lost_vec;
   logic               good_k;
   logic               abort_chk;

   // Lowest set bit wins so simultaneous events report the lowest rail.
   function automatic logic [2:0] lowest_idx(input logic [N_RAILS-1:0] vec);
      logic [2:0] idx;
      idx = '0;
      for (int i = N_RAILS - 1; i >= 0; i--) begin
         if (vec[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   // Decode the current rail and the abort conditions over enabled rails only;
   // a disabled rail's good/fault flags are don't-care.
   always_comb begin
      k_onehot = '0;
      for (int i = 0; i < N_RAILS; i++) begin
         k_onehot[i] = (k_q == 3'(i));
      end
      good_k    = |(i_railGood & k_onehot);
      fault_vec = en_q & i_railFault;
      lost_vec  = en_q & seen_q & ~i_railGood;
      abort_chk = (state_q == ST_ENABLE)  || (state_q == ST_DWELL) ||
                  (state_q == ST_RUNNING) || (state_q == ST_SHUTDOWN);
   end

   // Next-state logic: abort first, then stop request, then normal progress.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      seen_d  = seen_q;
      frail_d = frail_q;
      fcode_d = fcode_q;

      if (abort_chk && (|fault_vec)) begin
         // A rail fault outranks good-lost on the same cycle.
         state_d = ST_FAULT;
         fcode_d = CODE_RAIL;
         frail_d = lowest_idx(fault_vec);
      end else if (abort_chk && (|lost_vec)) begin
         state_d = ST_FAULT;
         fcode_d = CODE_LOST;
         frail_d = lowest_idx(lost_vec);
      end else begin
         case (state_q)
            ST_IDLE: begin
               seen_d = '0;
               if (i_start) begin
                  state_d = ST_ENABLE;
                  k_d     = '0;
               end
            end

            ST_ENABLE: begin
               if (!i_start) begin
                  state_d = ST_SHUTDOWN;
               end else if (good_k) begin
                  // Good is checked before timeout so a rail that turns good
                  // on the last allowed cycle is accepted.
                  state_d = ST_DWELL;
                  seen_d  = seen_q | k_onehot;
               end else if (cnt_q == TMO_LAST) begin
                  state_d = ST_FAULT;
                  fcode_d = CODE_TIMEOUT;
                  frail_d = k_q;
               end
            end

            ST_DWELL: begin
               if (!i_start) begin
                  state_d = ST_SHUTDOWN;
               end else if (cnt_q == DWELL_LAST) begin
                  if (k_q == K_LAST) begin
                     state_d = ST_RUNNING;
                  end else begin
                     state_d = ST_ENABLE;
                     k_d     = k_q + 3'd1;
                  end
               end
            end

            ST_RUNNING: begin
               if (!i_start) state_d = ST_SHUTDOWN;
            end

            ST_SHUTDOWN: begin
               // i_start is deliberately ignored until IDLE is reached.
               if (cnt_q == DWELL_LAST) begin
                  if (k_q == 3'd0) begin
                     state_d = ST_IDLE;
                  end else begin
                     k_d = k_q - 3'd1;
                  end
               end
            end

            ST_FAULT: begin
               seen_d = '0;
               if (i_clearFault && !i_start) begin
                  state_d = ST_IDLE;
                  fcode_d = CODE_NONE;
                  frail_d = '0;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      if (state_d == ST_FAULT) seen_d = '0;
   end

   // Counter restarts on any state or rail-index change, counts in timed states.
   always_comb begin
      cnt_d = '0;
      if ((state_d == state_q) && (k_d == k_q) &&
          ((state_q == ST_ENABLE) || (state_q == ST_DWELL) || (state_q == ST_SHUTDOWN))) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Output decode from the next state so every output is a plain register.
   always_comb begin
      en_d = '0;
      case (state_d)
         ST_ENABLE, ST_DWELL: begin
            for (int i = 0; i < N_RAILS; i++) en_d[i] = (3'(i) <= k_d);
         end
         ST_RUNNING: begin
            en_d = '1;
         end
         ST_SHUTDOWN: begin
            // Rail k is the one being switched off in this step.
            for (int i = 0; i < N_RAILS; i++) en_d[i] = (3'(i) < k_d);
         end
         default: begin
            en_d = '0;
         end
      endcase
      all_good_d = (state_d == ST_RUNNING);
      fault_d    = (state_d == ST_FAULT);
   end

   // State and output registers; reset drops every enable immediately.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         k_q        <= '0;
         cnt_q      <= '0;
         seen_q     <= '0;
         en_q       <= '0;
         all_good_q <= 1'b0;
         fault_q    <= 1'b0;
         frail_q    <= '0;
         fcode_q    <= CODE_NONE;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         cnt_q      <= cnt_d;
         seen_q     <= seen_d;
         en_q       <= en_d;
         all_good_q <= all_good_d;
         fault_q    <= fault_d;
         frail_q    <= frail_d;
         fcode_q    <= fcode_d;
      end
   end

   assign o_railEnable = en_q;
   assign o_allGood    = all_good_q;
   assign o_fault      = fault_q;
   assign o_faultRail  = frail_q;
   assign o_faultCode  = fcode_q;
   assign o_dbgState   = state_q;

endmodule

// File: tb/tb_power_sequencer.sv
// tb_power_sequencer: scenario tasks for power_sequencer with a behavioural
// rail-monitor model and a scoreboard of expected enable changes (value and
// cycle stamp) that is popped whenever o_railEnable changes.
module tb_power_sequencer;

   localparam int N   = 4;
   localparam int TMO = 100;
   localparam int DW  = 10;
   localparam int W   = 36;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ENABLE   = 3'd1;
   localparam logic [2:0] S_DWELL    = 3'd2;
   localparam logic [2:0] S_RUNNING  = 3'd3;
   localparam logic [2:0] S_SHUTDOWN = 3'd4;
   localparam logic [2:0] S_FAULT    = 3'd5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic         start = 1'b0;
   logic         clear_fault = 1'b0;
   logic [N-1:0] rail_good;
   logic [N-1:0] rail_fault = '0;
   logic [N-1:0] rail_en;
   logic         all_good;
   logic         fault;
   logic [2:0]   fault_rail;
   logic [1:0]   fault_code;
   logic [2:0]   dbg_state;

   power_sequencer #(
      .N_RAILS       (N),
      .TIMEOUT_CYCLES(TMO),
      .DWELL_CYCLES  (DW)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_clearFault(clear_fault),
      .i_railGood  (rail_good),
      .i_railFault (rail_fault),
      .o_railEnable(rail_en),
      .o_allGood   (all_good),
      .o_fault     (fault),
      .o_faultRail (fault_rail),
      .o_faultCode (fault_code),
      .o_dbgState  (dbg_state)
   );

   // ---------------- rail monitor model ----------------
   // A rail reports good once its enable has been high for dly[i] samples;
   // it drops good as soon as the enable goes away.
   int           dly[N] = '{20, 20, 20, 20};
   int           age[N] = '{0, 0, 0, 0};
   logic [N-1:0] never_good = '0;
   logic [N-1:0] drop_mask = '0;
   logic [N-1:0] good_mdl = '0;

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rail_en[i]) age[i] = age[i] + 1;
         else            age[i] = 0;
         good_mdl[i] = rail_en[i] && !never_good[i] && (age[i] >= dly[i]);
      end
   end

   assign rail_good = good_mdl & ~drop_mask;

   // ---------------- scoreboard ----------------
   int           checks = 0;
   int           failures = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] sb_exp;
   logic [N-1:0] last_en = '0;

   task automatic push_en(input logic [N-1:0] en, input int at);
      exp_q.push_back({32'(at), en});
   endtask

   always @(negedge clk) begin
      if (rail_en !== last_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL en_unexpected: got %b at cycle %0d, no change expected", rail_en, cyc);
         end else begin
            sb_exp = exp_q.pop_front();
            if ((rail_en !== sb_exp[N-1:0]) || (cyc != int'(sb_exp[W-1:N]))) begin
               failures++;
               $display("FAIL en_step: got %b at cycle %0d, want %b at cycle %0d",
                        rail_en, cyc, sb_exp[N-1:0], int'(sb_exp[W-1:N]));
            end
         end
         last_en = rail_en;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0) && (n < budget)) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d pending enable steps, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Raise start and queue the expected staircase; returns the RUNNING cycle.
   task automatic bring_up(output int t_run);
      int t;
      start = 1'b1;
      t = cyc + 1;
      for (int i = 0; i < N; i++) begin
         push_en(N'((1 << (i + 1)) - 1), t);
         t = t + dly[i] + DW;
      end
      t_run = t;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (rail_en !== 4'b0000) begin failures++; $display("FAIL rst_en: got %b want 0000", rail_en); end
      checks++; if (all_good !== 1'b0) begin failures++; $display("FAIL rst_allgood: got %b want 0", all_good); end
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL rst_fault: got %b want 0", fault); end
      checks++; if (fault_rail !== 3'd0) begin failures++; $display("FAIL rst_rail: got %0d want 0", fault_rail); end
      checks++; if (fault_code !== 2'b00) begin failures++; $display("FAIL rst_code: got %b want 00", fault_code); end
      checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL rst_state: got %0d want %0d", dbg_state, S_IDLE); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL rst_idle_hold: got %0d want %0d", dbg_state, S_IDLE); end
   endtask

   // Leaves the DUT in RUNNING for the shutdown scenario.
   task automatic test_normal_bringup();
      int t_run;
      bring_up(t_run);
      wait_until(t_run - 1);
      checks++; if (all_good !== 1'b0) begin failures++; $display("FAIL up_allgood_early: got %b want 0", all_good); end
      checks++; if (rail_en !== 4'b1111) begin failures++; $display("FAIL up_en_full: got %b want 1111", rail_en); end
      wait_until(t_run);
      checks++; if (all_good !== 1'b1) begin failures++; $display("FAIL up_allgood: got %b want 1", all_good); end
      checks++; if (dbg_state !== S_RUNNING) begin failures++; $display("FAIL up_state: got %0d want %0d", dbg_state, S_RUNNING); end
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL up_fault: got %b want 0", fault); end
      wait_drain(5);
   endtask

   task automatic test_ordered_shutdown();
      int s;
      @(negedge clk);
      s = cyc;
      start = 1'b0;
      push_en(4'b0111, s + 1);
      push_en(4'b0011, s + 1 + DW);
      push_en(4'b0001, s + 1 + 2 * DW);
      push_en(4'b0000, s + 1 + 3 * DW);
      wait_until(s + 1);
      checks++; if (all_good !== 1'b0) begin failures++; $display("FAIL sd_allgood: got %b want 0", all_good); end
      checks++; if (dbg_state !== S_SHUTDOWN) begin failures++; $display("FAIL sd_state: got %0d want %0d", dbg_state, S_SHUTDOWN); end
      // Re-assert start late in the shutdown; it must wait for IDLE.
      wait_until(s + 35);
      start = 1'b1;
      wait_until(s + 4 * DW);
      checks++; if (dbg_state !== S_SHUTDOWN) begin failures++; $display("FAIL sd_last_dwell: got %0d want %0d", dbg_state, S_SHUTDOWN); end
      push_en(4'b0001, s + 2 + 4 * DW);
      wait_until(s + 1 + 4 * DW);
      checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL sd_idle: got %0d want %0d", dbg_state, S_IDLE); end
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL sd_fault: got %b want 0", fault); end
      wait_until(s + 2 + 4 * DW);
      checks++; if (dbg_state !== S_ENABLE) begin failures++; $display("FAIL sd_restart: got %0d want %0d", dbg_state, S_ENABLE); end
      start = 1'b0;
      push_en(4'b0000, s + 3 + 4 * DW);
      wait_until(s + 3 + 5 * DW);
      checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL sd_idle2: got %0d want %0d", dbg_state, S_IDLE); end
      wait_drain(5);
   endtask

   task automatic test_timeout();
      int c0;
      never_good = 4'b0100;
      c0 = cyc;
      start = 1'b1;
      push_en(4'b0001, c0 + 1);
      push_en(4'b0011, c0 + 31);
      push_en(4'b0111, c0 + 61);
      push_en(4'b0000, c0 + 61 + TMO);
      wait_until(c0 + 60 + TMO);
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL tmo_early: got %b want 0", fault); end
      checks++; if (rail_en !== 4'b0111) begin failures++; $display("FAIL tmo_en_hold: got %b want 0111", rail_en); end
      wait_until(c0 + 61 + TMO);
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL tmo_fault: got %b want 1", fault); end
      checks++; if (fault_rail !== 3'd2) begin failures++; $display("FAIL tmo_rail: got %0d want 2", fault_rail); end
      checks++; if (fault_code !== 2'b01) begin failures++; $display("FAIL tmo_code: got %b want 01", fault_code); end
      start = 1'b0;
      clear_fault = 1'b1;
      @(negedge clk);
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL tmo_clear: got %b want 0", fault); end
      checks++; if (fault_code !== 2'b00) begin failures++; $display("FAIL tmo_code_clr: got %b want 00", fault_code); end
      checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL tmo_idle: got %0d want %0d", dbg_state, S_IDLE); end
      clear_fault = 1'b0;
      never_good = '0;
      wait_drain(5);
   endtask

   task automatic test_runtime_fault();
      int t_run;
      int f;
      bring_up(t_run);
      wait_until(t_run);
      f = cyc;
      rail_fault = 4'b0010;
      push_en(4'b0000, f + 1);
      @(negedge clk);
      rail_fault = 4'b0000;
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL rf_fault: got %b want 1", fault); end
      checks++; if (fault_code !== 2'b10) begin failures++; $display("FAIL rf_code: got %b want 10", fault_code); end
      checks++; if (fault_rail !== 3'd1) begin failures++; $display("FAIL rf_rail: got %0d want 1", fault_rail); end
      checks++; if (all_good !== 1'b0) begin failures++; $display("FAIL rf_allgood: got %b want 0", all_good); end
      clear_fault = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (dbg_state !== S_FAULT) begin failures++; $display("FAIL rf_hold_state: got %0d want %0d", dbg_state, S_FAULT); end
      checks++; if (fault_code !== 2'b10) begin failures++; $display("FAIL rf_hold_code: got %b want 10", fault_code); end
      start = 1'b0;
      @(negedge clk);
      checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL rf_idle: got %0d want %0d", dbg_state, S_IDLE); end
      checks++; if (fault_code !== 2'b00) begin failures++; $display("FAIL rf_code_clr: got %b want 00", fault_code); end
      checks++; if (fault_rail !== 3'd0) begin failures++; $display("FAIL rf_rail_clr: got %0d want 0", fault_rail); end
      clear_fault = 1'b0;
      wait_drain(5);
   endtask

   task automatic test_simul_good_lost();
      int t_run;
      int s;
      bring_up(t_run);
      wait_until(t_run);
      s = cyc;
      start = 1'b0;
      drop_mask = 4'b1000;
      push_en(4'b0000, s + 1);
      @(negedge clk);
      drop_mask = '0;
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL sim1_fault: got %b want 1", fault); end
      checks++; if (fault_code !== 2'b11) begin failures++; $display("FAIL sim1_code: got %b want 11", fault_code); end
      checks++; if (fault_rail !== 3'd3) begin failures++; $display("FAIL sim1_rail: got %0d want 3", fault_rail); end
      clear_fault = 1'b1;
      @(negedge clk);
      checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL sim1_idle: got %0d want %0d", dbg_state, S_IDLE); end
      clear_fault = 1'b0;
      wait_drain(5);
   endtask

   task automatic test_simul_good_on_timeout();
      int c0;
      dly[0] = TMO;
      c0 = cyc;
      start = 1'b1;
      push_en(4'b0001, c0 + 1);
      push_en(4'b0011, c0 + 1 + TMO + DW);
      wait_until(c0 + 1 + TMO);
      checks++; if (dbg_state !== S_DWELL) begin failures++; $display("FAIL sim2_dwell: got %0d want %0d", dbg_state, S_DWELL); end
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL sim2_fault: got %b want 0", fault); end
      wait_until(c0 + 1 + TMO + DW);
      checks++; if (dbg_state !== S_ENABLE) begin failures++; $display("FAIL sim2_next: got %0d want %0d", dbg_state, S_ENABLE); end
      start = 1'b0;
      push_en(4'b0001, c0 + 2 + TMO + DW);
      push_en(4'b0000, c0 + 2 + TMO + 2 * DW);
      wait_until(c0 + 2 + TMO + 3 * DW);
      checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL sim2_idle: got %0d want %0d", dbg_state, S_IDLE); end
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL sim2_nofault: got %b want 0", fault); end
      dly[0] = 20;
      wait_drain(5);
   endtask

   task automatic test_async_reset();
      int c0;
      @(negedge clk);
      c0 = cyc;
      start = 1'b1;
      push_en(4'b0001, c0 + 1);
      push_en(4'b0011, c0 + 31);
      wait_until(c0 + 55);
      checks++; if (dbg_state !== S_DWELL) begin failures++; $display("FAIL ar_in_dwell: got %0d want %0d", dbg_state, S_DWELL); end
      #2;
      rst = 1'b1;
      start = 1'b0;
      #1;
      checks++; if (rail_en !== 4'b0000) begin failures++; $display("FAIL ar_async_en: got %b want 0000", rail_en); end
      // The scoreboard notices the drop at the next falling edge.
      push_en(4'b0000, c0 + 56);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL ar_idle: got %0d want %0d", dbg_state, S_IDLE); end
      checks++; if (rail_en !== 4'b0000) begin failures++; $display("FAIL ar_en: got %b want 0000", rail_en); end
      checks++; if ({all_good, fault, fault_rail, fault_code} !== 7'd0) begin
         failures++;
         $display("FAIL ar_outputs: got %b%b %0d %b want all zero", all_good, fault, fault_rail, fault_code);
      end
      wait_drain(5);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_normal_bringup();
      test_ordered_shutdown();
      test_timeout();
      test_runtime_fault();
      test_simul_good_lost();
      test_simul_good_on_timeout();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: got time %0t, want completion earlier", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/power_sequencer.md
Name: power_sequencer

Overview:
- Sits directly downstream of the per-rail monitors.
- Consumes each rail's good and fault indications and drives the rail enable pins of the PMIC regulators.
- Brings rails up in ascending index order and takes them down in reverse order.
- Aborts to a latched all-off fault state on timeout, rail fault or loss of a good rail.

Parameters:
- N_RAILS, 4: number of sequenced rails (2..8); rail 0 is enabled first.
- TIMEOUT_CYCLES, 4000: maximum cycles from asserting a rail's enable to its good flag (1..65535).
- DWELL_CYCLES, 1000: settle cycles after each rail turns good, and between successive disables (1..65535).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  level; high = request rails on, low = request rails off.
- i_clearFault  in  1  clears a latched fault; honoured only while i_start is low.
- i_railGood  in  N_RAILS  per-rail good flags from the rail monitors.
- i_railFault  in  N_RAILS  per-rail fault flags (voltage OR current fault) from the rail monitors.
- o_railEnable  out  N_RAILS  regulator enable pins.
- o_allGood  out  1  high only in RUNNING.
- o_fault  out  1  high only in FAULT.
- o_faultRail  out  3  index of the rail that caused the fault.
- o_faultCode  out  2  fault cause: 00 none, 01 timeout, 10 rail fault, 11 good lost.

Behaviour:
- Reset, asynchronous:
  - State is IDLE; rail index k = 0; counter = 0.
  - All outputs are 0; o_faultRail = 0; o_faultCode = 00.
- All outputs are registered. Inputs are sampled on the rising edge of i_clk.
- Counter: 16-bit, cleared on every state change or change of k.
- States: IDLE, ENABLE, DWELL, RUNNING, SHUTDOWN, FAULT.
- IDLE:
  - All enables are 0.
  - If i_start is sampled high: go to ENABLE with k = 0. o_railEnable[0] = 1 in the next cycle.
- ENABLE(k):
  - o_railEnable[k:0] = 1; the counter increments each cycle.
  - If i_railGood[k] = 1: go to DWELL.
  - Otherwise, if counter == TIMEOUT_CYCLES-1: go to FAULT with code 01, rail k. A rail that turns good on exactly that cycle is accepted (good beats timeout).
- DWELL(k):
  - The counter increments each cycle.
  - When counter == DWELL_CYCLES-1:
    - If k == N_RAILS-1: go to RUNNING.
    - Otherwise: k = k+1 and go to ENABLE.
- RUNNING: all enables are 1; o_allGood = 1.
- SHUTDOWN, entered with k = highest enabled rail:
  - On entry, o_railEnable[k] is cleared in the next cycle. Wait DWELL_CYCLES.
  - If k == 0: go to IDLE.
  - Otherwise: k = k-1 and repeat.
  - The good flags of rails already disabled are ignored.
- Abort checks, applied in ENABLE, DWELL, RUNNING and SHUTDOWN, over currently enabled rails j only:
  - If i_railFault[j] = 1: go to FAULT, code 10, rail j.
  - If i_railGood[j] = 0 for any j that previously turned good: go to FAULT, code 11, rail j.
  - If several rails qualify, the lowest index is reported. A rail fault outranks good lost on the same cycle.
- Stop request: i_start sampled low in ENABLE, DWELL or RUNNING goes to SHUTDOWN at the current k.
- Priority: fault > stop > normal progress.
- FAULT:
  - All enables go to 0 in the cycle after detection (no reverse ordering).
  - o_fault = 1; o_faultRail and o_faultCode are held.
  - Leave to IDLE only when i_clearFault = 1 and i_start = 0 on the same cycle. The code then clears to 00.
  - i_start held high in FAULT has no effect.
- Reset mid-sequence: all enables drop immediately (asynchronous); the sequence restarts from IDLE.
- Re-assertion of i_start during SHUTDOWN is ignored until IDLE is reached.

Test Plan (N_RAILS=4, TIMEOUT_CYCLES=100, DWELL_CYCLES=10):
- Normal bring-up:
  - Stimulus: raise i_start; each rail monitor asserts good 20 cycles after its enable.
  - Response: enables step 0001→0011→0111→1111; each step follows good by 10 cycles; o_allGood = 1 after the final dwell; o_fault never set.
- Timeout:
  - Stimulus: rail 2 never reports good.
  - Response: exactly 100 cycles after o_railEnable[2] rises, enables = 0000 next cycle; o_fault = 1; o_faultRail = 2; o_faultCode = 01.
- Runtime fault:
  - Stimulus: in RUNNING, pulse i_railFault[1] for 1 cycle.
  - Response: enables = 0000 next cycle; o_faultCode = 10; o_faultRail = 1; state stays FAULT with i_clearFault = 1 while i_start = 1; reaches IDLE once i_start = 0.
- Ordered shutdown:
  - Stimulus: in RUNNING, drop i_start.
  - Response: enables 1111→0111→0011→0001→0000 at 10-cycle spacing; IDLE afterwards; no fault despite good flags dropping on disabled rails.
- Simultaneous events:
  - Stimulus 1: i_railGood[3] drops on the same cycle i_start drops. Response: FAULT, code 11, rail 3.
  - Stimulus 2: rail 0 goes good on the timeout cycle. Response: proceeds to DWELL, no fault.
- Async reset:
  - Stimulus: assert i_rst mid-DWELL(1), between clock edges.
  - Response: enables = 0000 without waiting for a clock edge; on release, IDLE with all outputs 0.
